key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Producer side of the controlkey bus. Turns raw, bouncing, asynchronous push-button inputs into
//  clean, synchronous per-key levels (controlkey, 1 = pressed) plus one-cycle press/release strobes.
//  Feeds the LED reaction logic and the game FSM.
//  Sits directly behind the board key pins. One independent channel per key.
// PARAMETERS
//  NKEYS        4      number of key channels
//  DB_CYCLES    20000  consecutive stable clk cycles required to accept a new level (>=2)
//  KEY_ACT_LOW  1      1: raw pin reads 0 when pressed; 0: raw pin reads 1 when pressed
//  CNT_W        $clog2(DB_CYCLES+1)  counter width (derived, do not override)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  key_in       in   NKEYS  raw key pins, asynchronous to clk
//  controlkey   out  NKEYS  debounced level per key, 1 = pressed (registered)
//  key_press    out  NKEYS  1-cycle strobe when controlkey[i] goes 0->1
//  key_release  out  NKEYS  1-cycle strobe when controlkey[i] goes 1->0
//  any_press    out  1      OR of key_press, same cycle
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0.
//   Synchronizer flops load the "released" level (KEY_ACT_LOW ? 1 : 0). Counters 0. Channel state RELEASED.
//  Sync: 2-flop synchronizer per key. Polarity is normalised after sync2: pressed_raw = sync2 ^ KEY_ACT_LOW.
//  Per-channel FSM (2 bits): RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
//   RELEASED:     pressed_raw=1 -> PRESS_PEND, cnt<=1.
//   PRESS_PEND:   pressed_raw=0 -> RELEASED, cnt<=0 (glitch discarded).
//                 else if cnt==DB_CYCLES-1 -> PRESSED, cnt<=0, controlkey<=1, key_press<=1.
//                 else cnt<=cnt+1.
//   PRESSED / RELEASE_PEND: mirror image with pressed_raw=0; accept -> RELEASED, key_release<=1.
//  Latency: a clean edge on key_in is first sampled at edge k. controlkey changes at edge k+DB_CYCLES+1
//   (i.e. the (DB_CYCLES+2)th edge counting k). The strobe rises on that same edge.
//  Strobes: high exactly one cycle, only on accepted transitions. Never both press and release in one cycle per key.
//  Glitch rule: any single cycle of pressed_raw matching the current stable level restarts the count from 0.
//   Bursts shorter than DB_CYCLES never reach the outputs.
//  Counter saturates by construction: never exceeds DB_CYCLES-1. No wrap-around.
//  Channels are fully independent. Simultaneous presses on several keys give simultaneous strobes.
//   any_press is asserted once for that cycle.
//  Reset mid-debounce: pending count is discarded. After release, a still-held key needs the full
//   DB_CYCLES+2 edges again and produces one fresh key_press.
//  Unused FSM encodings recover to RELEASED next cycle, with outputs 0.
// STRUCTURE
//  Package key_pkg: typedef key_st_t {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND}; default DB_CYCLES constant.
//  Sub-module key_debounce_ch, one key: sync + FSM + counter + level/strobe regs.
//   The top generate-loops NKEYS instances and ORs key_press into any_press.
// TESTING  (DB_CYCLES=4, KEY_ACT_LOW=1, NKEYS=4)
//  1 Reset: hold rst_n=0, key_in=4'b0000 -> all outputs 0.
//    Release with key_in=4'b1111 -> outputs stay 0 for 20 cycles.
//  2 Clean press: key_in[0] 1->0 sampled at edge k -> controlkey=4'b0001 at edge k+5.
//    key_press=4'b0001 and any_press=1 for exactly that one cycle.
//    Releasing the key gives key_release[0] 5 edges after its sample.
//  3 Bounce: key_in[1] low 3 cycles, high 1, low 3, high -> controlkey[1] never 1, no strobes.
//    Then hold low 6 cycles -> exactly one key_press[1].
//  4 Simultaneous: key_in 1111->0101 on one edge -> controlkey=4'b1010 on the same edge.
//    key_press=4'b1010, any_press=1 for one cycle.
//  5 Reset mid-operation: key_in[2] held low, assert rst_n at cnt=2 for 1 cycle.
//    -> outputs 0 immediately (async). key_press[2] arrives 6 edges after reset release.
//  6 Polarity: KEY_ACT_LOW=0, key_in[3] 0->1 held -> controlkey[3]=1 after 6 edges.
//    Reset value of the sync flops is 0, and no spurious strobe occurs.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the key debounce block.
package key_pkg;

   localparam int DB_CYCLES_DEFAULT = 20000;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } key_st_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered level and one-cycle press/release strobes.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
   parameter bit KEY_ACT_LOW = 1'b1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_key,
   output logic    o_level,
   output logic    o_press,
   output logic    o_release,
   output key_st_t o_state
);

   localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             r_sync1;
   logic             r_sync2;
   key_st_t          r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_pressed_raw;

   assign w_pressed_raw = r_sync2 ^ KEY_ACT_LOW;
   assign o_state       = r_state;

   // Synchronizers reset to the idle pin level so release never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= KEY_ACT_LOW;
         r_sync2   <= KEY_ACT_LOW;
         r_state   <= RELEASED;
         r_cnt     <= '0;
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
      end else begin
         r_sync1   <= i_key;
         r_sync2   <= r_sync1;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         case (r_state)
            RELEASED: begin
               if (w_pressed_raw) begin
                  r_state <= PRESS_PEND;
                  r_cnt   <= CNT_ONE;
               end
            end
            PRESS_PEND: begin
               if (!w_pressed_raw) begin
                  r_state <= RELEASED;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
                  o_level <= 1'b1;
                  o_press <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!w_pressed_raw) begin
                  r_state <= RELEASE_PEND;
                  r_cnt   <= CNT_ONE;
               end
            end
            RELEASE_PEND: begin
               if (w_pressed_raw) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= RELEASED;
                  r_cnt     <= '0;
                  o_level   <= 1'b0;
                  o_release <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= RELEASED;
               r_cnt   <= '0;
               o_level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Debounces NKEYS raw push-button pins into clean levels and press/release strobes.
module key_debounce
   import key_pkg::*;
#(
   parameter int NKEYS       = 4,
   parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
   parameter bit KEY_ACT_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NKEYS-1:0]   key_in,
   output logic [NKEYS-1:0]   controlkey,
   output logic [NKEYS-1:0]   key_press,
   output logic [NKEYS-1:0]   key_release,
   output logic               any_press,
   output logic [2*NKEYS-1:0] dbg_state
);

   for (genvar i = 0; i < NKEYS; i++) begin : g_ch
      key_st_t w_state;

      key_debounce_ch #(
         .DB_CYCLES   (DB_CYCLES),
         .KEY_ACT_LOW (KEY_ACT_LOW)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_key     (key_in[i]),
         .o_level   (controlkey[i]),
         .o_press   (key_press[i]),
         .o_release (key_release[i]),
         .o_state   (w_state)
      );

      assign dbg_state[2*i +: 2] = w_state;
   end

   assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=4: table-driven vectors
// plus hand-written sequences for bounce, mid-debounce reset and polarity.
module tb_key_debounce;

   localparam int NK = 4;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key_in;
   logic [NK-1:0] controlkey, key_press, key_release;
   logic          any_press;
   logic [2*NK-1:0] dbg_state;

   logic [NK-1:0] key_in_hi;
   logic [NK-1:0] controlkey_hi, key_press_hi, key_release_hi;
   logic          any_press_hi;
   logic [2*NK-1:0] dbg_state_hi;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [NK-1:0] key;
      logic [NK-1:0] ck;
      logic [NK-1:0] pr;
      logic [NK-1:0] rl;
      logic          any;
   } vec_t;

   vec_t vecs[$];

   key_debounce #(.NKEYS(NK), .DB_CYCLES(DB), .KEY_ACT_LOW(1'b1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .controlkey  (controlkey),
      .key_press   (key_press),
      .key_release (key_release),
      .any_press   (any_press),
      .dbg_state   (dbg_state)
   );

   key_debounce #(.NKEYS(NK), .DB_CYCLES(DB), .KEY_ACT_LOW(1'b0)) u_dut_hi (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in_hi),
      .controlkey  (controlkey_hi),
      .key_press   (key_press_hi),
      .key_release (key_release_hi),
      .any_press   (any_press_hi),
      .dbg_state   (dbg_state_hi)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // compares {controlkey, key_press, key_release, any_press} of the active-low instance
   task automatic chk_out(input string name, input logic [NK-1:0] ck, input logic [NK-1:0] pr,
                          input logic [NK-1:0] rl, input logic an);
      chk(name, {19'd0, controlkey, key_press, key_release, any_press},
                {19'd0, ck, pr, rl, an});
   endtask

   task automatic push_n(input int n, input logic [NK-1:0] k, input logic [NK-1:0] ck,
                         input logic [NK-1:0] pr, input logic [NK-1:0] rl);
      vec_t v;
      v.key = k; v.ck = ck; v.pr = pr; v.rl = rl; v.any = |pr;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   initial begin
      int first_edge;
      int n_press;
      int n_rel;

      // clean press/release of key 0, then simultaneous press of keys 1 and 3
      push_n(5, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
      push_n(1, 4'b1110, 4'b0001, 4'b0001, 4'b0000);
      push_n(2, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
      push_n(5, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
      push_n(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
      push_n(2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      push_n(5, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
      push_n(1, 4'b0101, 4'b1010, 4'b1010, 4'b0000);
      push_n(2, 4'b0101, 4'b1010, 4'b0000, 4'b0000);
      push_n(5, 4'b1111, 4'b1010, 4'b0000, 4'b0000);
      push_n(1, 4'b1111, 4'b0000, 4'b0000, 4'b1010);
      push_n(2, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

      // reset held with pins reading "pressed"
      key_in    = 4'b0000;
      key_in_hi = 4'b0000;
      rst_n     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("reset_outputs", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
      chk("reset_hi_outputs", {28'd0, controlkey_hi | key_press_hi | key_release_hi}, 32'd0);

      key_in = 4'b1111;
      rst_n  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_out("idle_after_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
         chk("idle_state", {24'd0, dbg_state}, 32'd0);
         chk("idle_hi_state", {24'd0, dbg_state_hi}, 32'd0);
      end

      // table-driven vectors
      foreach (vecs[i]) begin
         key_in = vecs[i].key;
         tick();
         chk_out($sformatf("vec%0d", i), vecs[i].ck, vecs[i].pr, vecs[i].rl, vecs[i].any);
      end

      // bounce on key 1: low 3, high 1, low 3, then high
      for (int i = 0; i < 15; i++) begin
         key_in = (i < 3 || (i >= 4 && i < 7)) ? 4'b1101 : 4'b1111;
         tick();
         chk_out("bounce_quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end

      // held key 1: exactly one press, on the 6th edge counting the first sample
      first_edge = 0;
      n_press    = 0;
      key_in     = 4'b1101;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (key_press[1]) begin
            n_press++;
            if (first_edge == 0) first_edge = i;
         end
      end
      chk("bounce_hold_press_edge", first_edge, 32'd6);
      chk("bounce_hold_press_count", n_press, 32'd1);
      chk("bounce_hold_level", {28'd0, controlkey}, 32'h2);
      key_in = 4'b1111;
      for (int i = 0; i < 8; i++) tick();
      chk("bounce_release_level", {28'd0, controlkey}, 32'h0);

      // reset while key 2 is mid-debounce (count at 2)
      key_in = 4'b1011;
      for (int i = 0; i < 4; i++) tick();
      chk("pre_reset_pending", {30'd0, dbg_state[5:4]}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_out("async_reset_outputs", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk("async_reset_state", {24'd0, dbg_state}, 32'd0);
      tick();
      rst_n      = 1'b1;
      first_edge = 0;
      n_press    = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (key_press[2]) begin
            n_press++;
            if (first_edge == 0) first_edge = i;
         end
      end
      chk("post_reset_press_edge", first_edge, 32'd6);
      chk("post_reset_press_count", n_press, 32'd1);
      chk("post_reset_level", {28'd0, controlkey}, 32'h4);
      key_in = 4'b1111;
      for (int i = 0; i < 8; i++) tick();

      // active-high polarity instance, key 3
      first_edge = 0;
      n_press    = 0;
      n_rel      = 0;
      key_in_hi  = 4'b1000;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (key_press_hi[3]) begin
            n_press++;
            if (first_edge == 0) first_edge = i;
         end
         if (|key_release_hi) n_rel++;
         if (|key_press_hi[2:0]) n_press++;
      end
      chk("hi_press_edge", first_edge, 32'd6);
      chk("hi_press_count", n_press, 32'd1);
      chk("hi_release_count", n_rel, 32'd0);
      chk("hi_level", {28'd0, controlkey_hi}, 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
